// File: rtl/serial_vector_detector.sv
// rtl/serial_vector_detector.sv - serial-input sliding-window pattern detector
// One bit per valid cycle into a WIDTH-bit window, masked compare, registered match pulse and saturating count.
module serial_vector_detector #(
  parameter int WIDTH = 9,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             cfg_load,
  input  logic [WIDTH-1:0] cfg_pattern,
  input  logic [WIDTH-1:0] cfg_mask,
  input  logic             cfg_overlap,
  output logic [WIDTH-1:0] window,
  output logic             armed,
  output logic             match,
  output logic [CNT_W-1:0] match_count,
  output logic             count_sat
);

  localparam int FILL_W = ($clog2(WIDTH + 1) < 4) ? 4 : $clog2(WIDTH + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(WIDTH);

  localparam logic [0:0] ST_FILL  = 1'b0;
  localparam logic [0:0] ST_ARMED = 1'b1;

  logic [WIDTH-1:0]  pattern_q, pattern_d;
  logic [WIDTH-1:0]  mask_q, mask_d;
  logic              overlap_q, overlap_d;
  logic [WIDTH-1:0]  window_q, window_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [0:0]        state_q, state_d;
  logic              match_q, match_d;
  logic [CNT_W-1:0]  match_count_q, match_count_d;
  logic              count_sat_q, count_sat_d;
  logic [FILL_W-1:0] fill_inc;
  logic              hit;

  always_comb begin
    pattern_d     = pattern_q;
    mask_d        = mask_q;
    overlap_d     = overlap_q;
    window_d      = window_q;
    fill_d        = fill_q;
    state_d       = state_q;
    match_d       = 1'b0;
    match_count_d = match_count_q;
    count_sat_d   = count_sat_q;
    fill_inc      = fill_q;
    hit           = 1'b0;

    if (cfg_load) begin
      // A bit arriving with cfg_load is deliberately dropped.
      pattern_d     = cfg_pattern;
      mask_d        = cfg_mask;
      overlap_d     = cfg_overlap;
      window_d      = '0;
      fill_d        = '0;
      state_d       = ST_FILL;
      match_count_d = '0;
      count_sat_d   = 1'b0;
    end else if (in_valid) begin
      window_d = {window_q[WIDTH-2:0], in_bit};
      fill_inc = (fill_q == FILL_FULL) ? fill_q : fill_q + 1'b1;
      fill_d   = fill_inc;
      state_d  = (fill_inc == FILL_FULL) ? ST_ARMED : ST_FILL;
      hit      = (fill_inc == FILL_FULL) && (((window_d ^ pattern_q) & mask_q) == '0);
      if (hit) begin
        match_d = 1'b1;
        if (match_count_q != '1) begin
          match_count_d = match_count_q + 1'b1;
        end
        if (match_count_d == '1) begin
          count_sat_d = 1'b1;
        end
        // Non-overlap: the window must refill completely before the next match.
        if (!overlap_q) begin
          fill_d  = '0;
          state_d = ST_FILL;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pattern_q     <= '0;
      mask_q        <= '1;
      overlap_q     <= 1'b1;
      window_q      <= '0;
      fill_q        <= '0;
      state_q       <= ST_FILL;
      match_q       <= 1'b0;
      match_count_q <= '0;
      count_sat_q   <= 1'b0;
    end else begin
      pattern_q     <= pattern_d;
      mask_q        <= mask_d;
      overlap_q     <= overlap_d;
      window_q      <= window_d;
      fill_q        <= fill_d;
      state_q       <= state_d;
      match_q       <= match_d;
      match_count_q <= match_count_d;
      count_sat_q   <= count_sat_d;
    end
  end

  assign window      = window_q;
  assign armed       = (state_q == ST_ARMED);
  assign match       = match_q;
  assign match_count = match_count_q;
  assign count_sat   = count_sat_q;

endmodule

// File: tb/tb_serial_vector_detector.sv
// tb/tb_serial_vector_detector.sv - bench for serial_vector_detector
// Two instances (16-bit and 4-bit counters) share stimulus; both are checked against a queue-based model.
module tb_serial_vector_detector;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_bit = 1'b0;
  logic       cfg_load = 1'b0;
  logic [8:0] cfg_pattern = '0;
  logic [8:0] cfg_mask = '1;
  logic       cfg_overlap = 1'b1;

  logic [8:0]  window, window4;
  logic        armed, armed4, match, match4, count_sat, count_sat4;
  logic [15:0] match_count;
  logic [3:0]  match_count4;

  serial_vector_detector #(.WIDTH(9), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_mask(cfg_mask), .cfg_overlap(cfg_overlap),
    .window(window), .armed(armed), .match(match), .match_count(match_count), .count_sat(count_sat)
  );

  serial_vector_detector #(.WIDTH(9), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_mask(cfg_mask), .cfg_overlap(cfg_overlap),
    .window(window4), .armed(armed4), .match(match4), .match_count(match_count4), .count_sat(count_sat4)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: accepted bits kept as a queue, unsaturated match total.
  bit         m_bits[$];
  logic [8:0] m_pat, m_mask;
  bit         m_ovl;
  int         m_run, m_total;
  bit         m_match;

  typedef struct {
    logic       v;
    logic       b;
    logic       e_match;
    logic       e_armed;
    int         e_cnt;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [8:0] m_window();
    logic [8:0] w = '0;
    foreach (m_bits[i]) w = {w[7:0], m_bits[i]};
    return w;
  endfunction

  function automatic bit m_compare(input logic [8:0] w);
    for (int i = 0; i < 9; i++)
      if (m_mask[i] && (w[i] != m_pat[i])) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_pat = '0; m_mask = '1; m_ovl = 1'b1;
    m_bits.delete(); m_run = 0; m_total = 0; m_match = 1'b0;
  endtask

  task automatic model_step(input logic ld, input logic v, input logic b,
                            input logic [8:0] p, input logic [8:0] m, input logic o);
    m_match = 1'b0;
    if (ld) begin
      m_pat = p; m_mask = m; m_ovl = o;
      m_bits.delete(); m_run = 0; m_total = 0;
    end else if (v) begin
      m_bits.push_back(b);
      if (m_bits.size() > 9) void'(m_bits.pop_front());
      m_run++;
      if (m_run >= 9 && m_compare(m_window())) begin
        m_match = 1'b1;
        m_total++;
        if (!m_ovl) m_run = 0;
      end
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".window"}, 32'(window), 32'(m_window()));
    chk({tag, ".armed"}, 32'(armed), 32'(m_run >= 9));
    chk({tag, ".match"}, 32'(match), 32'(m_match));
    chk({tag, ".count"}, 32'(match_count), (m_total > 65535) ? 32'd65535 : 32'(m_total));
    chk({tag, ".sat"}, 32'(count_sat), 32'(m_total >= 65535));
    chk({tag, ".match4"}, 32'(match4), 32'(m_match));
    chk({tag, ".count4"}, 32'(match_count4), (m_total > 15) ? 32'd15 : 32'(m_total));
    chk({tag, ".sat4"}, 32'(count_sat4), 32'(m_total >= 15));
  endtask

  task automatic cycle(input string tag, input logic ld, input logic v, input logic b,
                       input logic [8:0] p, input logic [8:0] m, input logic o);
    cfg_load = ld; in_valid = v; in_bit = b;
    cfg_pattern = p; cfg_mask = m; cfg_overlap = o;
    @(posedge clk); #1;
    model_step(ld, v, b, p, m, o);
    check_model(tag);
    cfg_load = 1'b0; in_valid = 1'b0; in_bit = 1'b0;
  endtask

  task automatic push(input string tag, input logic b);
    cycle(tag, 1'b0, 1'b1, b, cfg_pattern, cfg_mask, cfg_overlap);
  endtask

  task automatic idle(input string tag);
    cycle(tag, 1'b0, 1'b0, 1'b0, cfg_pattern, cfg_mask, cfg_overlap);
  endtask

  task automatic load(input logic [8:0] p, input logic [8:0] m, input logic o);
    cycle("load", 1'b1, 1'b0, 1'b0, p, m, o);
  endtask

  initial begin
    int n_low;
    int n_sweep;
    logic [8:0] vec;
    logic [8:0] gapvec;

    for (int i = 1; i <= 10; i++)
      tbl.push_back('{v: 1'b1, b: 1'b0, e_match: (i >= 9), e_armed: (i >= 9),
                      e_cnt: (i < 9) ? 0 : i - 8});

    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset.window", 32'(window), 32'h0);
    chk("reset.armed", 32'(armed), 32'h0);
    chk("reset.match", 32'(match), 32'h0);
    chk("reset.count", 32'(match_count), 32'h0);
    chk("reset.sat", 32'(count_sat), 32'h0);
    rst = 1'b0;

    // Reset defaults: pattern 0, full mask, overlap on.
    foreach (tbl[i]) begin
      cycle("tbl", 1'b0, tbl[i].v, tbl[i].b, 9'h000, 9'h1FF, 1'b1);
      chk("tbl.match", 32'(match), 32'(tbl[i].e_match));
      chk("tbl.armed", 32'(armed), 32'(tbl[i].e_armed));
      chk("tbl.count", 32'(match_count), 32'(tbl[i].e_cnt));
    end
    chk("defaults.window", 32'(window), 32'h0);

    load(9'h1FF, 9'h1FF, 1'b1);
    for (int i = 1; i <= 18; i++) push("ovl1", 1'b1);
    chk("ovl1.count", 32'(match_count), 32'd10);

    load(9'h1FF, 9'h1FF, 1'b0);
    n_low = 0;
    for (int i = 1; i <= 18; i++) begin
      push("ovl0", 1'b1);
      if (i == 9 || i == 18) chk("ovl0.match", 32'(match), 32'd1);
      else chk("ovl0.nomatch", 32'(match), 32'd0);
      if (i >= 10 && i <= 17 && !armed) n_low++;
    end
    chk("ovl0.count", 32'(match_count), 32'd2);
    chk("ovl0.armed_low", 32'(n_low), 32'd8);

    // Only end bits compared; an in_valid gap mid-vector is invisible.
    load(9'b101010101, 9'h101, 1'b1);
    gapvec = 9'h100 | 9'($urandom_range(0, 127) << 1) | 9'h001;
    for (int i = 8; i >= 0; i--) begin
      push("gap", gapvec[i]);
      if (i == 5) repeat (3) idle("gap.idle");
    end
    chk("gap.count", 32'(match_count), 32'd1);
    chk("gap.window", 32'(window), 32'(gapvec));

    n_sweep = 0;
    for (int v = 0; v < 512; v++) begin
      load(9'h0A5, 9'h1FF, 1'b0);
      vec = 9'(v);
      for (int i = 8; i >= 0; i--) push("sweep", vec[i]);
      chk("sweep.count", 32'(match_count), 32'(v == 9'h0A5));
      n_sweep += int'(match_count);
    end
    chk("sweep.total", 32'(n_sweep), 32'd1);

    // cfg_load wins over a simultaneous bit.
    load(9'h1FF, 9'h1FF, 1'b1);
    for (int i = 0; i < 4; i++) push("coll.pre", 1'b1);
    cycle("coll", 1'b1, 1'b1, 1'b1, 9'h1FF, 9'h1FF, 1'b1);
    chk("coll.window", 32'(window), 32'h0);
    chk("coll.armed", 32'(armed), 32'h0);
    chk("coll.count", 32'(match_count), 32'h0);
    for (int i = 1; i <= 9; i++) begin
      push("coll.post", 1'b1);
      chk("coll.match", 32'(match), 32'(i == 9));
    end

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 63) == 0)
        load(9'($urandom), 9'($urandom & $urandom & $urandom), 1'($urandom));
      else
        cycle("rand", 1'b0, 1'($urandom_range(0, 3) != 0), 1'($urandom),
              cfg_pattern, cfg_mask, cfg_overlap);
    end

    load(9'h1FF, 9'h1FF, 1'b1);
    for (int i = 0; i < 30; i++) push("sat", 1'b1);
    chk("sat.count4", 32'(match_count4), 32'd15);
    chk("sat.flag4", 32'(count_sat4), 32'd1);
    chk("sat.match4", 32'(match4), 32'd1);
    chk("sat.count16", 32'(match_count), 32'd22);

    #2 rst = 1'b1;
    #1;
    chk("arst.window", 32'(window4), 32'h0);
    chk("arst.armed", 32'(armed4), 32'h0);
    chk("arst.match", 32'(match4), 32'h0);
    chk("arst.count", 32'(match_count4), 32'h0);
    chk("arst.sat", 32'(count_sat4), 32'h0);
    chk("arst.count16", 32'(match_count), 32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      cycle("post_rst", 1'b0, 1'b1, 1'b0, 9'h000, 9'h1FF, 1'b1);
      chk("post_rst.match", 32'(match), 32'(i == 9));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
